multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Instruction sequencer for the 18-bit CPU; the producer side of the ALU and register file control interface.
- Owns PC and IR, fetches 18-bit instructions over a ready-handshake memory port, and decodes them.
- Drives ALUControl, register-file read/write addresses, write strobe and immediates to the datapath through a multi-cycle FSM.
- Sits between unified memory and the datapath (ALU, RegisterFile, MDR).

Parameters:
PC_WIDTH, 10, width of PC and memory address; PC arithmetic wraps modulo 2^PC_WIDTH.
RESET_PC, 0, PC value loaded on reset.

Ports:
Clock  in  1  single system clock, rising edge.
Clear  in  1  asynchronous, active-low reset.
MemRData  in  18  memory read data (instruction in FETCH).
MemReady  in  1  memory completes the current access this cycle.
CmpEq  in  1  datapath: ReadData1 == ReadData2.
CmpGt  in  1  datapath: ReadData1 > ReadData2, signed.
MemAddr  out  PC_WIDTH  memory address.
MemRead  out  1  read request, held until MemReady.
MemWrite  out  1  write request, held until MemReady; data = ReadData2.
ReadAddress1  out  4  register file read port 1.
ReadAddress2  out  4  register file read port 2.
WriteAddress  out  4  register file write address.
RegWrite  out  1  register write strobe, one cycle.
WBSel  out  1  write-back source: 0 = ALU result, 1 = MDR.
ALUControl  out  2  00 add, 01 and, 10 nand, 11 nor.
ALUSrcB  out  1  0 = ReadData2, 1 = Imm.
Imm  out  18  extended immediate.
PC  out  PC_WIDTH  current PC.
Halted  out  1  HALT executed.

Behaviour:
- Instruction format. Opcode is IR[17:14].
  - R-type: rd[13:10], rs1[9:6], rs2[5:2].
  - I-type: rd[13:10], rs1[9:6], imm6[5:0] signed.
  - LD/ST: reg[13:10], addr[9:0] absolute.
  - Branch: rs1[13:10], rs2[9:6], off6[5:0] signed.
  - JUMP: off14[13:0] signed.
- Opcodes:
  - 0 ADD, 1 ADDI, 2 AND, 3 ANDI, 4 NAND, 5 NOR, 6 LD, 7 ST.
  - 8 JUMP, 9 BEQ, A BGT, B BLT, C BGE, D BLE, E NOP, F HALT.
- Reset (Clear low, async): state = FETCH, PC = RESET_PC, IR = 0. All strobes 0 while Clear is low (MemRead, MemWrite, RegWrite), Halted = 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: MemAddr = PC, MemRead = 1.
  - Hold while MemReady = 0.
  - On MemReady: IR <= MemRData, PC <= PC+1 (wraps), go to DECODE.
- DECODE:
  - JUMP: PC <= PC + off14 (truncated to PC_WIDTH), go to FETCH.
  - Branches: if taken, PC <= PC + sext(off6); go to FETCH either way. PC here is already incremented.
  - Branch conditions: BEQ = CmpEq; BGT = CmpGt; BLT = !CmpGt & !CmpEq; BGE = CmpGt | CmpEq; BLE = !CmpGt.
  - ALU ops go to EXEC. LD/ST go to MEM. NOP goes to FETCH. HALT goes to HALT.
- EXEC: ALUControl and ALUSrcB valid (I-type: ALUSrcB = 1); go to WB.
- MEM: MemAddr = IR[9:0].
  - LD asserts MemRead, ST asserts MemWrite; held until MemReady.
  - Datapath MDR captures MemRData on MemRead & MemReady.
  - On MemReady, LD goes to WB and ST goes to FETCH.
- WB: RegWrite = 1 for exactly one cycle, WriteAddress = IR[13:10], WBSel = 1 for LD, else 0; go to FETCH.
- HALT: Halted = 1, sticky. No memory or register strobes. MemReady ignored. Exit only via Clear.
- Read addresses, decoded combinationally from IR:
  - R/I-type: RA1 = IR[9:6], RA2 = IR[5:2].
  - Branch: RA1 = IR[13:10], RA2 = IR[9:6].
  - ST: RA2 = IR[13:10].
  - Otherwise: 0.
- ALUControl: ADD/ADDI = 00, AND/ANDI = 01, NAND = 10, NOR = 11; 00 otherwise.
- Imm: I-type = sext(IR[5:0]); LD/ST = zext(IR[9:0]); else 0.
- Latency with zero-wait memory:
  - ALU op and LD: 4 cycles.
  - ST: 3 cycles.
  - Branch, JUMP, NOP: 2 cycles.
  - Each MemReady-low cycle adds one cycle.
- Clear asserted mid-access abandons the access immediately; no partial RegWrite or MemWrite occurs.
- MemReady outside FETCH/MEM is ignored.

Test Plan:
- Reset mid-operation: Clear low during FETCH with MemReady = 0 -> MemRead = 0, PC = 0, Halted = 0. After release, FETCH resumes at address 0.
- ADDI: fetch 0x0443D (ADDI R1,R0,-3), zero-wait -> RA1 = 0, ALUSrcB = 1, Imm = 0x3FFFD, ALUControl = 00. Fourth cycle: RegWrite = 1, WriteAddress = 1, WBSel = 0. PC 0 -> 1.
- LD with MemReady delayed 3 cycles in MEM -> MemRead held 4 cycles at MemAddr = IR[9:0]. Next cycle: RegWrite = 1, WBSel = 1.
- BEQ at PC = 5, off6 = -2:
  - CmpEq = 1 -> PC = 4.
  - CmpEq = 0 -> PC = 6.
  - BLE with CmpGt = 0 -> taken.
  - BLT with CmpEq = 1 -> not taken.
- Wrap: instruction at PC = 1023 -> PC = 0 after fetch. JUMP off14 = +1 -> PC = 1.
- HALT at PC = 2 -> Halted = 1, no strobes for 20 cycles despite MemReady toggling. Clear pulse -> PC = 0, Halted = 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer for the 18-bit CPU: owns PC/IR, fetches over a
// ready-handshake memory port and drives ALU / register-file control to the datapath.
module multicycle_control_unit #(
    parameter int unsigned         PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic [17:0]         MemRData,
    input  logic                MemReady,
    input  logic                CmpEq,
    input  logic                CmpGt,
    output logic [PC_WIDTH-1:0] MemAddr,
    output logic                MemRead,
    output logic                MemWrite,
    output logic [3:0]          ReadAddress1,
    output logic [3:0]          ReadAddress2,
    output logic [3:0]          WriteAddress,
    output logic                RegWrite,
    output logic                WBSel,
    output logic [1:0]          ALUControl,
    output logic                ALUSrcB,
    output logic [17:0]         Imm,
    output logic [PC_WIDTH-1:0] PC,
    output logic                Halted
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpAddi = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpAndi = 4'h3;
    localparam logic [3:0] OpNand = 4'h4;
    localparam logic [3:0] OpNor  = 4'h5;
    localparam logic [3:0] OpLd   = 4'h6;
    localparam logic [3:0] OpSt   = 4'h7;
    localparam logic [3:0] OpJump = 4'h8;
    localparam logic [3:0] OpBeq  = 4'h9;
    localparam logic [3:0] OpBgt  = 4'hA;
    localparam logic [3:0] OpBlt  = 4'hB;
    localparam logic [3:0] OpBge  = 4'hC;
    localparam logic [3:0] OpBle  = 4'hD;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [PC_WIDTH-1:0] PcOne = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [17:0]         ir_q, ir_d;

    logic [3:0]          opcode;
    logic                is_alu, is_itype, is_branch, is_mem, br_taken;
    logic [PC_WIDTH-1:0] off14_ext, off6_ext, ir_addr;

    assign opcode    = ir_q[17:14];
    assign is_alu    = (opcode <= OpNor);
    assign is_itype  = (opcode == OpAddi) || (opcode == OpAndi);
    assign is_branch = (opcode >= OpBeq) && (opcode <= OpBle);
    assign is_mem    = (opcode == OpLd) || (opcode == OpSt);
    assign off14_ext = PC_WIDTH'($signed(ir_q[13:0]));
    assign off6_ext  = PC_WIDTH'($signed(ir_q[5:0]));
    assign ir_addr   = PC_WIDTH'(ir_q[9:0]);

    always_comb begin
        br_taken = 1'b0;
        unique case (opcode)
            OpBeq:   br_taken = CmpEq;
            OpBgt:   br_taken = CmpGt;
            OpBlt:   br_taken = !CmpGt && !CmpEq;
            OpBge:   br_taken = CmpGt || CmpEq;
            OpBle:   br_taken = !CmpGt;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StFetch: begin
                if (MemReady) begin
                    ir_d    = MemRData;
                    pc_d    = pc_q + PcOne;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // pc_q already points past this instruction, so offsets are PC+1 relative.
                state_d = StFetch;
                if (opcode == OpJump) begin
                    pc_d = pc_q + off14_ext;
                end else if (is_branch && br_taken) begin
                    pc_d = pc_q + off6_ext;
                end
                if (is_alu) begin
                    state_d = StExec;
                end else if (is_mem) begin
                    state_d = StMem;
                end else if (opcode == OpHalt) begin
                    state_d = StHalt;
                end
            end
            StExec:  state_d = StWb;
            StMem: begin
                if (MemReady) begin
                    state_d = (opcode == OpLd) ? StWb : StFetch;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Strobes are gated by Clear so nothing is asserted while reset is held.
    always_comb begin
        MemAddr  = pc_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        unique case (state_q)
            StFetch: MemRead = Clear;
            StMem: begin
                MemAddr  = ir_addr;
                MemRead  = Clear && (opcode == OpLd);
                MemWrite = Clear && (opcode == OpSt);
            end
            StWb:    RegWrite = Clear;
            default: ;
        endcase
    end

    always_comb begin
        ReadAddress1 = 4'd0;
        ReadAddress2 = 4'd0;
        if (is_alu) begin
            ReadAddress1 = ir_q[9:6];
            ReadAddress2 = ir_q[5:2];
        end else if (is_branch) begin
            ReadAddress1 = ir_q[13:10];
            ReadAddress2 = ir_q[9:6];
        end else if (opcode == OpSt) begin
            ReadAddress2 = ir_q[13:10];
        end
    end

    always_comb begin
        ALUControl = 2'b00;
        unique case (opcode)
            OpAdd, OpAddi: ALUControl = 2'b00;
            OpAnd, OpAndi: ALUControl = 2'b01;
            OpNand:        ALUControl = 2'b10;
            OpNor:         ALUControl = 2'b11;
            default:       ALUControl = 2'b00;
        endcase
    end

    always_comb begin
        Imm = 18'd0;
        if (is_itype) begin
            Imm = {{12{ir_q[5]}}, ir_q[5:0]};
        end else if (is_mem) begin
            Imm = {8'd0, ir_q[9:0]};
        end
    end

    assign ALUSrcB      = is_itype;
    assign WriteAddress = ir_q[13:10];
    assign WBSel        = (opcode == OpLd);
    assign PC           = pc_q;
    assign Halted       = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, multi-cycle corner
// sequences and a randomized program run against an instruction-level model.
module tb_multicycle_control_unit;

    localparam logic [17:0] NopInst  = 18'h38000;
    localparam logic [17:0] HaltInst = 18'h3C000;

    logic        Clock, Clear, MemReady, CmpEq, CmpGt;
    logic [17:0] MemRData;
    logic [9:0]  MemAddr, PC;
    logic        MemRead, MemWrite, RegWrite, WBSel, ALUSrcB, Halted;
    logic [3:0]  ReadAddress1, ReadAddress2, WriteAddress;
    logic [1:0]  ALUControl;
    logic [17:0] Imm;

    logic [17:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  pc_m;

    assign MemRData = mem[MemAddr];

    multicycle_control_unit #(.PC_WIDTH(10), .RESET_PC(10'd0)) dut (
        .Clock(Clock), .Clear(Clear), .MemRData(MemRData), .MemReady(MemReady),
        .CmpEq(CmpEq), .CmpGt(CmpGt), .MemAddr(MemAddr), .MemRead(MemRead),
        .MemWrite(MemWrite), .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
        .WriteAddress(WriteAddress), .RegWrite(RegWrite), .WBSel(WBSel),
        .ALUControl(ALUControl), .ALUSrcB(ALUSrcB), .Imm(Imm), .PC(PC), .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [17:0] inst;
        logic        ceq;
        logic        cgt;
        logic [9:0]  pc0;
        logic [9:0]  exp_pc;
        int          cyc;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [17:0] imm;
        logic [1:0]  alu;
        logic        srcb;
        int          rw;
        int          mw;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        Clear = 1'b0;
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
        #1;
    endtask

    task automatic fill_nop();
        for (int a = 0; a < 1024; a++) mem[a] = NopInst;
    endtask

    // Instruction-level reference rules.
    function automatic logic [7:0] exp_ra(input logic [17:0] i);
        case (i[17:14])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: return {i[9:6], i[5:2]};
            4'h9, 4'hA, 4'hB, 4'hC, 4'hD:       return {i[13:10], i[9:6]};
            4'h7:                               return {4'h0, i[13:10]};
            default:                            return 8'h00;
        endcase
    endfunction

    function automatic logic [1:0] exp_alu(input logic [3:0] op);
        case (op)
            4'h2, 4'h3: return 2'b01;
            4'h4:       return 2'b10;
            4'h5:       return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic [17:0] exp_imm(input logic [17:0] i);
        case (i[17:14])
            4'h1, 4'h3: return {{12{i[5]}}, i[5:0]};
            4'h6, 4'h7: return {8'h00, i[9:0]};
            default:    return 18'h0;
        endcase
    endfunction

    function automatic logic taken(input logic [3:0] op, input logic eq, input logic gt);
        case (op)
            4'h9:    return eq;
            4'hA:    return gt;
            4'hB:    return !gt && !eq;
            4'hC:    return gt || eq;
            4'hD:    return !gt;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one instruction from the model PC with random wait states and compare flags.
    task automatic exec_one();
        logic [17:0] inst;
        logic [3:0]  op;
        logic [9:0]  npc;
        logic        rdy, ceq, cgt;
        int          w, r;
        inst = mem[pc_m];
        op   = inst[17:14];
        w    = 0;
        do begin
            rdy = (w >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            chk("fetch_read", MemRead, 1);
            chk("fetch_addr", MemAddr, pc_m);
            chk("fetch_quiet", {MemWrite, RegWrite, Halted}, 0);
            MemReady = rdy;
            w++;
            @(negedge Clock);
        end while (!rdy);
        npc = pc_m + 10'd1;
        r   = $urandom_range(0, 2);
        ceq = (r == 0);
        cgt = (r == 1);
        CmpEq = ceq;
        CmpGt = cgt;
        MemReady = 1'($urandom_range(0, 1));
        chk("dec_pc", PC, npc);
        chk("dec_ra", {ReadAddress1, ReadAddress2}, exp_ra(inst));
        chk("dec_quiet", {MemRead, MemWrite, RegWrite}, 0);
        if (op == 4'h8) npc = npc + inst[9:0];
        else if (taken(op, ceq, cgt)) npc = npc + {{4{inst[5]}}, inst[5:0]};
        @(negedge Clock);
        if (op <= 4'h5) begin
            chk("exec_alu", ALUControl, exp_alu(op));
            chk("exec_srcb", ALUSrcB, (op == 4'h1) || (op == 4'h3));
            chk("exec_imm", Imm, exp_imm(inst));
            chk("exec_quiet", {MemRead, MemWrite, RegWrite}, 0);
            MemReady = 1'($urandom_range(0, 1));
            @(negedge Clock);
            chk("wb_we", {RegWrite, WBSel, MemRead, MemWrite}, 4'b1000);
            chk("wb_addr", WriteAddress, inst[13:10]);
            MemReady = 1'($urandom_range(0, 1));
            @(negedge Clock);
        end else if (op == 4'h6 || op == 4'h7) begin
            w = 0;
            do begin
                rdy = (w >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
                chk("mem_addr", MemAddr, inst[9:0]);
                chk("mem_strobe", {MemRead, MemWrite, RegWrite}, (op == 4'h6) ? 3'b100 : 3'b010);
                chk("mem_imm", Imm, exp_imm(inst));
                if (op == 4'h7) chk("st_ra2", ReadAddress2, inst[13:10]);
                MemReady = rdy;
                w++;
                @(negedge Clock);
            end while (!rdy);
            if (op == 4'h6) begin
                chk("ld_wb", {RegWrite, WBSel, MemRead, MemWrite}, 4'b1100);
                chk("ld_wb_addr", WriteAddress, inst[13:10]);
                MemReady = 1'($urandom_range(0, 1));
                @(negedge Clock);
            end
        end
        pc_m = npc;
        chk("next_pc", PC, pc_m);
    endtask

    initial begin
        vec_t       v;
        logic [9:0] pinc;
        int         rw, mw;
        logic [31:0] rnd;

        Clear = 1'b0; MemReady = 1'b0; CmpEq = 1'b0; CmpGt = 1'b0;
        fill_nop();

        vecs[0]  = '{18'h0443D, 0, 0, 10'd0,    10'd1, 4, 4'h0, 4'hF, 18'h3FFFD, 2'b00, 1, 1, 0};
        vecs[1]  = '{18'h248FE, 1, 0, 10'd5,    10'd4, 2, 4'h2, 4'h3, 18'h0,     2'b00, 0, 0, 0};
        vecs[2]  = '{18'h248FE, 0, 0, 10'd5,    10'd6, 2, 4'h2, 4'h3, 18'h0,     2'b00, 0, 0, 0};
        vecs[3]  = '{18'h348FE, 0, 0, 10'd5,    10'd4, 2, 4'h2, 4'h3, 18'h0,     2'b00, 0, 0, 0};
        vecs[4]  = '{18'h2C8FE, 1, 0, 10'd5,    10'd6, 2, 4'h2, 4'h3, 18'h0,     2'b00, 0, 0, 0};
        vecs[5]  = '{18'h288FE, 0, 1, 10'd5,    10'd4, 2, 4'h2, 4'h3, 18'h0,     2'b00, 0, 0, 0};
        vecs[6]  = '{18'h308FE, 0, 0, 10'd5,    10'd6, 2, 4'h2, 4'h3, 18'h0,     2'b00, 0, 0, 0};
        vecs[7]  = '{18'h20001, 0, 0, 10'd1023, 10'd1, 2, 4'h0, 4'h0, 18'h0,     2'b00, 0, 0, 0};
        vecs[8]  = '{18'h38000, 0, 0, 10'd3,    10'd4, 2, 4'h0, 4'h0, 18'h0,     2'b00, 0, 0, 0};
        vecs[9]  = '{18'h00C48, 0, 0, 10'd7,    10'd8, 4, 4'h1, 4'h2, 18'h0,     2'b00, 0, 1, 0};
        vecs[10] = '{18'h11158, 0, 0, 10'd7,    10'd8, 4, 4'h5, 4'h6, 18'h0,     2'b10, 0, 1, 0};
        vecs[11] = '{18'h15158, 0, 0, 10'd7,    10'd8, 4, 4'h5, 4'h6, 18'h0,     2'b11, 0, 1, 0};
        vecs[12] = '{18'h0C8C5, 0, 0, 10'd7,    10'd8, 4, 4'h3, 4'h1, 18'h5,     2'b01, 1, 1, 0};
        vecs[13] = '{18'h1DD55, 0, 0, 10'd9,    10'd10, 3, 4'h0, 4'h7, 18'h155,  2'b00, 0, 0, 1};
        vecs[14] = '{18'h1A2AA, 0, 0, 10'd9,    10'd10, 4, 4'h0, 4'h0, 18'h2AA,  2'b00, 0, 1, 0};

        // Reset values while Clear is held.
        #1;
        chk("reset_strobes", {MemRead, MemWrite, RegWrite, Halted}, 0);
        chk("reset_pc", PC, 0);
        do_reset();

        // Directed table, zero-wait memory.
        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            fill_nop();
            if (v.pc0 != 10'd0) mem[0] = {4'h8, 4'h0, v.pc0 - 10'd1};
            mem[v.pc0] = v.inst;
            CmpEq = v.ceq; CmpGt = v.cgt; MemReady = 1'b1;
            do_reset();
            if (v.pc0 != 10'd0) repeat (2) @(negedge Clock);
            chk("vec_start", {MemRead, MemAddr}, {1'b1, v.pc0});
            pinc = v.pc0 + 10'd1;
            rw = 0; mw = 0;
            for (int c = 0; c < v.cyc; c++) begin
                if (RegWrite) rw++;
                if (MemWrite) mw++;
                if (c == 1) begin
                    chk("vec_pc_inc", PC, pinc);
                    chk("vec_ra", {ReadAddress1, ReadAddress2}, {v.ra1, v.ra2});
                    chk("vec_imm", Imm, v.imm);
                    chk("vec_alu", {ALUControl, ALUSrcB}, {v.alu, v.srcb});
                end
                @(negedge Clock);
            end
            chk("vec_next_pc", PC, v.exp_pc);
            chk("vec_next_fetch", {MemRead, MemAddr}, {1'b1, v.exp_pc});
            chk("vec_regwrite_cnt", rw, v.rw);
            chk("vec_memwrite_cnt", mw, v.mw);
        end

        // Clear during a stalled fetch.
        fill_nop();
        MemReady = 1'b1;
        do_reset();
        repeat (2) @(negedge Clock);
        MemReady = 1'b0;
        @(negedge Clock);
        chk("stall_fetch", {MemRead, MemAddr}, {1'b1, 10'd1});
        Clear = 1'b0;
        #1;
        chk("clr_fetch_strobes", {MemRead, MemWrite, RegWrite, Halted}, 0);
        chk("clr_fetch_pc", PC, 0);
        @(negedge Clock);
        Clear = 1'b1; MemReady = 1'b1;
        #1;
        chk("clr_fetch_resume", {MemRead, MemAddr, PC}, {1'b1, 10'd0, 10'd0});

        // LD with three wait states in MEM.
        fill_nop();
        mem[0] = 18'h1A2AA;
        MemReady = 1'b1;
        do_reset();
        repeat (2) @(negedge Clock);
        rw = 0;
        for (int k = 0; k < 4; k++) begin
            if (MemRead && MemAddr == 10'h2AA && !RegWrite) rw++;
            MemReady = (k == 3);
            @(negedge Clock);
        end
        chk("ld_wait_read_cycles", rw, 4);
        chk("ld_wait_wb", {RegWrite, WBSel, MemRead}, 3'b110);
        MemReady = 1'b1;
        @(negedge Clock);
        chk("ld_wait_next", {RegWrite, MemRead, MemAddr}, {1'b0, 1'b1, 10'd1});

        // Clear during a stalled store abandons it.
        fill_nop();
        mem[0] = 18'h1DD55;
        MemReady = 1'b1;
        do_reset();
        @(negedge Clock);
        MemReady = 1'b0;
        @(negedge Clock);
        chk("st_stall", {MemWrite, MemAddr}, {1'b1, 10'h155});
        Clear = 1'b0;
        #1;
        chk("clr_st_strobes", {MemRead, MemWrite, RegWrite}, 0);
        @(negedge Clock);
        chk("clr_st_hold", {MemRead, MemWrite, RegWrite}, 0);
        Clear = 1'b1; MemReady = 1'b1;
        #1;
        chk("clr_st_resume", {MemRead, MemAddr, PC}, {1'b1, 10'd0, 10'd0});

        // HALT at PC 2 is sticky and silent until Clear.
        fill_nop();
        mem[2] = HaltInst;
        MemReady = 1'b1;
        do_reset();
        repeat (6) @(negedge Clock);
        chk("halt_pc", PC, 3);
        for (int k = 0; k < 20; k++) begin
            MemReady = 1'($urandom_range(0, 1));
            chk("halt_state", {Halted, MemRead, MemWrite, RegWrite}, 4'b1000);
            @(negedge Clock);
        end
        Clear = 1'b0;
        #1;
        chk("halt_clear", {Halted, PC}, {1'b0, 10'd0});
        @(negedge Clock);
        Clear = 1'b1;

        // Random program against the instruction-level model.
        for (int a = 0; a < 1024; a++) begin
            rnd = $urandom;
            mem[a] = (rnd[17:14] == 4'hF) ? {4'hE, rnd[13:0]} : rnd[17:0];
        end
        MemReady = 1'b0;
        do_reset();
        pc_m = 10'd0;
        for (int n = 0; n < 300; n++) exec_one();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
